mod_alu_pipe: RTL
=================

Name: mod_alu_pipe

Overview:
Parametrised, fully pipelined modular arithmetic unit over Z_Q for the NTT/polynomial datapath. It supports add, sub, mul and multiply-accumulate (a*b+c) with generic-Q Barrett reduction. It has a fixed latency for every op and valid/ready handshakes with backpressure. A user tag travels with each operation, so butterfly and accumulate controllers can issue mixed ops back-to-back.

Parameters:
Q, 3329, modulus; must be odd and satisfy 2^(W-1) < Q < 2^W and Q*(Q+1) < 4^W
W, 12, operand/result width in bits
TAGW, 4, width of the pass-through tag
MU (localparam), floor(4^W / Q), Barrett constant; 5039 for the defaults

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  operation present on inputs
in_ready  out  1  unit accepts the operation this cycle
op  in  2  0=add, 1=sub, 2=mul, 3=mac (a*b+c)
a  in  W  operand a, contract a < Q
b  in  W  operand b, contract b < Q
c  in  W  addend for mac (ignored otherwise), contract c < Q
tag_in  in  TAGW  user tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
result  out  W  modular result, always < Q
tag_out  out  TAGW  tag of the result
err  out  1  sticky: some accepted operand was >= Q

Behaviour:
- Reset: when reset is low, all stage valids, out_valid, result, tag_out and err clear to 0 immediately and asynchronously. In-flight operations are discarded. After release the unit is empty.
- Pipeline: 4 stages, S1..S4. Global advance en = !out_valid || out_ready. in_ready = en (combinational). An op is accepted on a cycle where in_valid && in_ready.
- Latency: exactly 4 cycles from acceptance to out_valid, for every op, when there is no stall. Throughput is 1 op per cycle. Result order equals issue order.
- S1 (capture):
  - mul: t = a*b.
  - mac: t = a*b + c (2W+1 bits).
  - add: s = a+b, corrected by subtracting Q if s >= Q.
  - sub: a-b, plus Q if a < b.
  - op, tag and add/sub results are registered.
- S2: q1 = t[2W-1:W-1]*MU registered. t is delayed alongside.
- S3: qQ = (q1 >> (W+1))*Q registered. t is delayed alongside.
- S4: r = t - qQ, which lies in [0, 3Q). Apply up to two conditional subtractions of Q. Register result and tag. For add/sub, S4 just registers the delayed S1 value.
- Stall: when en=0, every stage register and the outputs hold, and in_ready=0. result and tag_out stay stable while out_valid && !out_ready.
- Bubbles: an idle input cycle (in_valid=0 with en=1) propagates as a stage-valid 0. out_valid drops for exactly that slot.
- Simultaneous events: on a cycle with out_valid && out_ready && in_valid, the output is consumed and the new op is accepted in the same cycle.
- Out-of-contract operands:
  - err sets on an accepted op whose a >= Q or b >= Q, or whose op=3 and c >= Q.
  - err stays set until reset.
  - result is still produced and still < Q after the corrections, but its value is unspecified.
- No combinational path from in_valid, op, a, b or c to any output. in_ready depends only on out_valid and out_ready.

Decomposition:
- Shared package mod_pkg holds:
  - op encoding constants (OP_ADD, OP_SUB, OP_MUL, OP_MAC)
  - the default Q, W and the MU computation function, so that every modular block derives the same constant.
- One sub-module, barrett_reduce_pipe. It is parametrised by Q and W, has an enable input, and implements S2–S4 with valid passthrough.
- Add/sub, the handshake and the tag delay line stay in mod_alu_pipe.

Test Plan:
- Add: Q=3329, op=0, a=3000, b=400, tag=5 -> 4 cycles later result=71, tag_out=5.
- Sub and mul back-to-back: (op=1, 5, 10) then (op=2, 3328, 3328) -> results 3324 then 1 on consecutive cycles.
- Mac: op=3, a=1234, b=2000, c=17 -> 1228. Also a=b=c=3328 -> 0.
- Backpressure: stream 8 random ops and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, no loss or duplication, order preserved, all results match a golden model (a op b) mod Q.
- Reset mid-operation: 3 ops in flight, assert reset low asynchronously (off-edge) -> out_valid=0 and err=0 immediately. The first op accepted after release emerges 4 cycles later, correct.
- Contract violation: op=0, a=3329 -> err=1 and stays 1 through later legal ops, and result < 3329.

Source files
------------

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared op encoding, default modulus and Barrett constant
//
// Purpose: common definitions for every modular-arithmetic block, so that all
// of them derive the same Barrett constant from (Q, W).
//   Q_DEFAULT / W_DEFAULT : default modulus and operand width
//   op_e                  : operation encoding (add, sub, mul, mac)
//   barrett_mu(q, w)      : floor(4^w / q)
package mod_pkg;

  localparam int Q_DEFAULT = 3329;
  localparam int W_DEFAULT = 12;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAC = 2'd3
  } op_e;

  // Result fits in w+1 bits because q > 2^(w-1).
  function automatic longint unsigned barrett_mu(input int unsigned q, input int unsigned w);
    longint unsigned num;
    num = 64'd1 << (2 * w);
    return num / 64'(q);
  endfunction

endpackage

// File: rtl/barrett_reduce_pipe.sv
// rtl/barrett_reduce_pipe.sv - three-stage Barrett reduction of a 2W+1 bit value mod Q
//
// Purpose: reduces t (< 4^W) to t mod Q in three enabled register stages.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   en                  : pipeline advance; all stages hold when low
//   in_valid, t         : value to reduce and its valid flag
//   out_valid, result   : reduced value (< Q) and its valid flag
module barrett_reduce_pipe
  import mod_pkg::*;
#(
  parameter int Q = Q_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           in_valid,
  input  logic [2*W:0]   t,
  output logic           out_valid,
  output logic [W-1:0]   result
);

  localparam int TW = 2 * W + 1;
  localparam int PW = 2 * W + 2;
  localparam logic [W:0]    MU  = (W+1)'(barrett_mu(Q, W));
  localparam logic [TW-1:0] Q_T = TW'(Q);

  logic          v2, v3, v4;
  logic [PW-1:0] q1, q1_d;
  logic [TW-1:0] t2, t3, qq3, qq_d, r0, r1, r2;
  logic          unused_bits;

  assign q1_d = PW'(t[2*W-1:W-1]) * PW'(MU);
  assign qq_d = TW'(q1[PW-1:W+1]) * Q_T;

  // The quotient estimate undershoots by at most 2, so r0 < 3Q.
  assign r0 = t3 - qq3;
  assign r1 = (r0 >= Q_T) ? r0 - Q_T : r0;
  assign r2 = (r1 >= Q_T) ? r1 - Q_T : r1;

  assign unused_bits = ^{q1[W:0], r2[TW-1:W]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2     <= 1'b0;
      v3     <= 1'b0;
      v4     <= 1'b0;
      q1     <= '0;
      t2     <= '0;
      t3     <= '0;
      qq3    <= '0;
      result <= '0;
    end else if (en) begin
      v2     <= in_valid;
      q1     <= q1_d;
      t2     <= t;
      v3     <= v2;
      qq3    <= qq_d;
      t3     <= t2;
      v4     <= v3;
      result <= r2[W-1:0];
    end
  end

  assign out_valid = v4;

endmodule

// File: rtl/mod_alu_pipe.sv
// rtl/mod_alu_pipe.sv - four-stage modular add/sub/mul/mac unit over Z_Q with handshakes
//
// Purpose: fixed 4-cycle latency modular ALU with a pass-through tag.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   in_valid, in_ready    : input handshake
//   op, a, b, c, tag_in   : operation (0 add, 1 sub, 2 mul, 3 mac), operands, tag
//   out_valid, out_ready  : output handshake
//   result, tag_out       : modular result (< Q) and its tag
//   err                   : sticky flag, an accepted operand was >= Q
module mod_alu_pipe
  import mod_pkg::*;
#(
  parameter int Q    = Q_DEFAULT,
  parameter int W    = W_DEFAULT,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    c,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    result,
  output logic [TAGW-1:0] tag_out,
  output logic            err
);

  localparam int TW = 2 * W + 1;
  localparam logic [W-1:0] Q_W = W'(Q);
  localparam logic [W:0]   Q_X = (W+1)'(Q);

  logic            en, accept, bad_op, is_mul_d;
  logic [W-1:0]    a_f, b_f, sub_d, addsub_d, red_result;
  logic [W:0]      sum, sum_m;
  logic [TW-1:0]   t_d, t1;
  logic            v1, mul1, mul2, mul3, mul4;
  logic [W-1:0]    as1, as2, as3, as4;
  logic [TAGW-1:0] tag1, tag2, tag3, tag4;
  logic            unused_bits;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Fold operands once so add/sub stay below Q even when the contract is broken.
  assign a_f = (a >= Q_W) ? a - Q_W : a;
  assign b_f = (b >= Q_W) ? b - Q_W : b;

  assign sum   = {1'b0, a_f} + {1'b0, b_f};
  assign sum_m = (sum >= Q_X) ? sum - Q_X : sum;
  // a_f - b_f wraps mod 2^W when negative; adding Q lands it in [1, Q).
  assign sub_d    = (a_f >= b_f) ? a_f - b_f : a_f - b_f + Q_W;
  assign addsub_d = (op == OP_SUB) ? sub_d : sum_m[W-1:0];

  assign t_d      = TW'(a) * TW'(b) + ((op == OP_MAC) ? TW'(c) : TW'(0));
  assign is_mul_d = (op == OP_MUL) || (op == OP_MAC);
  assign bad_op   = (a >= Q_W) || (b >= Q_W) || ((op == OP_MAC) && (c >= Q_W));

  assign unused_bits = sum_m[W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err  <= 1'b0;
      v1   <= 1'b0;
      t1   <= '0;
      mul1 <= 1'b0;
      mul2 <= 1'b0;
      mul3 <= 1'b0;
      mul4 <= 1'b0;
      as1  <= '0;
      as2  <= '0;
      as3  <= '0;
      as4  <= '0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
      tag4 <= '0;
    end else begin
      if (accept && bad_op) begin
        err <= 1'b1;
      end
      if (en) begin
        v1   <= in_valid;
        t1   <= t_d;
        mul1 <= is_mul_d;
        as1  <= addsub_d;
        tag1 <= tag_in;
        mul2 <= mul1;
        as2  <= as1;
        tag2 <= tag1;
        mul3 <= mul2;
        as3  <= as2;
        tag3 <= tag2;
        mul4 <= mul3;
        as4  <= as3;
        tag4 <= tag3;
      end
    end
  end

  barrett_reduce_pipe #(
    .Q(Q),
    .W(W)
  ) u_reduce (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (v1),
    .t         (t1),
    .out_valid (out_valid),
    .result    (red_result)
  );

  // Both sources are registers, so the output mux adds no input-to-output path.
  assign result  = mul4 ? red_result : as4;
  assign tag_out = tag4;

endmodule
